// File: rtl/minst_fetch_seq_if.sv
// minst_fetch_seq_if: request, serial link and result handshake bundle of the micro-instruction fetch sequencer
interface minst_fetch_seq_if #(
  parameter int ADDR_WIDTH  = 10,
  parameter int MINST_WIDTH = 44
);
  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic                   mem_sel;
  logic                   m_inst_addr_stream;
  logic                   minstr_in;
  logic                   minst_valid;
  logic                   minst_ready;
  logic [MINST_WIDTH-1:0] minst;
  logic                   busy;
  modport slave (
    input  req_valid, req_addr, minstr_in, minst_ready,
    output req_ready, mem_sel, m_inst_addr_stream, minst_valid, minst, busy
  );
  modport master (
    output req_valid, req_addr, minstr_in, minst_ready,
    input  req_ready, mem_sel, m_inst_addr_stream, minst_valid, minst, busy
  );
endinterface

// File: rtl/minst_fetch_seq.sv
// minst_fetch_seq: serialises a micro-address out, shifts the micro-instruction back in and hands it over
module minst_fetch_seq #(
  parameter int ADDR_WIDTH  = 10,
  parameter int MINST_WIDTH = 44,
  parameter int TURNAROUND  = 2
) (
  input logic              sys_clk,
  input logic              sys_reset,
  minst_fetch_seq_if.slave bus
);
  localparam int MAX_AT = ADDR_WIDTH > TURNAROUND ? ADDR_WIDTH : TURNAROUND;
  localparam int MAX_C  = MAX_AT > MINST_WIDTH ? MAX_AT : MINST_WIDTH;
  localparam int CW     = $clog2(MAX_C + 1);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TURNAROUND > 0 ? TURNAROUND - 1 : 0);
  localparam logic [CW-1:0] DATA_LAST = CW'(MINST_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, ADDR, WAIT, DATA, HOLD} state_t;
  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [MINST_WIDTH-1:0] minst_q;
  logic                   mem_sel_q;
  logic                   stream_q;
  logic                   valid_q;
  logic                   cnt_zero;
  assign cnt_zero               = cnt_q == '0;
  assign bus.req_ready          = state_q == IDLE && !sys_reset;
  assign bus.busy               = state_q != IDLE;
  assign bus.mem_sel            = mem_sel_q;
  assign bus.m_inst_addr_stream = stream_q;
  assign bus.minst_valid        = valid_q;
  assign bus.minst              = minst_q;
  // Frame sequencer: the counter holds the remaining beats of the current phase minus one
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      minst_q   <= '0;
      mem_sel_q <= 1'b0;
      stream_q  <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          state_q   <= ADDR;
          cnt_q     <= ADDR_LAST;
          stream_q  <= bus.req_addr[ADDR_WIDTH-1];
          addr_q    <= {bus.req_addr[ADDR_WIDTH-2:0], 1'b0};
          minst_q   <= '0;
          mem_sel_q <= 1'b1;
        end
        ADDR: if (cnt_zero) begin
          state_q  <= TURNAROUND == 0 ? DATA : WAIT;
          cnt_q    <= TURNAROUND == 0 ? DATA_LAST : WAIT_LAST;
          stream_q <= 1'b0;
        end else begin
          cnt_q    <= cnt_q - ONE;
          stream_q <= addr_q[ADDR_WIDTH-1];
          addr_q   <= {addr_q[ADDR_WIDTH-2:0], 1'b0};
        end
        WAIT: if (cnt_zero) begin
          state_q <= DATA;
          cnt_q   <= DATA_LAST;
        end else begin
          cnt_q <= cnt_q - ONE;
        end
        DATA: begin
          minst_q <= {minst_q[MINST_WIDTH-2:0], bus.minstr_in};
          cnt_q   <= cnt_zero ? '0 : cnt_q - ONE;
          if (cnt_zero) begin
            state_q   <= HOLD;
            mem_sel_q <= 1'b0;
            valid_q   <= 1'b1;
          end
        end
        HOLD: if (bus.minst_ready) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_minst_fetch_seq.sv
// tb_minst_fetch_seq: table, corner-case and random checks of the fetch sequencer against a frame-phase model
module tb_minst_fetch_seq;
  localparam int AW = 10;
  localparam int MW = 44;
  localparam int TA = 2;
  localparam int F  = AW + TA + MW;
  localparam int F0 = AW + MW;
  typedef struct {
    logic [AW-1:0] addr;
    logic [MW-1:0] word;
    int            stall;
    logic [AW-1:0] exp_stream;
    logic [MW-1:0] exp_minst;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit m_act = 1'b0;
  int m_t = 0;
  logic [AW-1:0] m_addr = '0;
  logic [MW-1:0] m_word = '0;
  logic [MW-1:0] m_kept = '0;
  logic [MW-1:0] m_next = '0;
  int n_acc = 0;
  int last_acc = 0;
  int acc_gap = 0;
  int ones = 0;
  logic [AW-1:0] seen = '0;
  logic [AW-1:0] addr0 = 10'h2A5;
  logic [MW-1:0] w0 = 44'h5A5C3C39669;
  vec_t tab [4];
  always #5 clk = ~clk;
  minst_fetch_seq_if #(.ADDR_WIDTH(AW), .MINST_WIDTH(MW)) bus ();
  minst_fetch_seq_if #(.ADDR_WIDTH(AW), .MINST_WIDTH(MW)) bus0 ();
  minst_fetch_seq #(.ADDR_WIDTH(AW), .MINST_WIDTH(MW), .TURNAROUND(TA)) dut (
    .sys_clk(clk), .sys_reset(rst), .bus(bus)
  );
  minst_fetch_seq #(.ADDR_WIDTH(AW), .MINST_WIDTH(MW), .TURNAROUND(0)) dut0 (
    .sys_clk(clk), .sys_reset(rst), .bus(bus0)
  );
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", n, cyc, act, exp);
    end
  endtask
  function automatic logic [MW-1:0] exp_minst();
    int s;
    if (!m_act) return m_kept;
    s = m_t - AW - TA;
    if (s <= 0) return '0;
    return m_word >> (MW - s);
  endfunction
  task automatic step(input logic r, input logic rv, input logic [AW-1:0] a, input logic mr);
    @(negedge clk);
    rst = r;
    bus.req_valid = rv;
    bus.req_addr = a;
    bus.minst_ready = mr;
    bus.minstr_in = (m_act && m_t >= AW + TA && m_t < F) ? m_word[MW-1-(m_t-AW-TA)] : 1'($urandom);
    #1;
    chk("mem_sel", bus.mem_sel, m_act && m_t < F);
    chk("stream", bus.m_inst_addr_stream, (m_act && m_t < AW) ? m_addr[AW-1-m_t] : 1'b0);
    chk("valid", bus.minst_valid, m_act && m_t >= F);
    chk("busy", bus.busy, m_act);
    chk("req_ready", bus.req_ready, !m_act && !r);
    chk("minst", bus.minst, exp_minst());
    if (m_act && m_t < AW) seen = {seen[AW-2:0], bus.m_inst_addr_stream};
    ones += int'(bus.m_inst_addr_stream);
    @(posedge clk);
    cyc++;
    if (r) begin
      m_act = 1'b0;
      m_kept = '0;
    end else if (!m_act) begin
      if (rv) begin
        m_act = 1'b1;
        m_t = 0;
        m_addr = a;
        m_word = m_next;
        acc_gap = cyc - last_acc;
        last_acc = cyc;
        n_acc++;
      end
    end else if (m_t >= F) begin
      if (mr) begin
        m_act = 1'b0;
        m_kept = m_word;
      end
    end else begin
      m_t++;
    end
  endtask
  task automatic fetch(input vec_t v);
    m_next = v.word;
    seen = '0;
    step(1'b0, 1'b1, v.addr, 1'b0);
    for (int i = 0; i < 200 && m_act && m_t < F; i++) step(1'b0, 1'b0, ~v.addr, 1'b0);
    #2;
    chk("tab_stream", seen, v.exp_stream);
    chk("tab_minst", bus.minst, v.exp_minst);
    chk("tab_valid", bus.minst_valid, 1'b1);
    for (int i = 0; i < v.stall; i++) step(1'b0, i % 4 == 0, ~v.addr, 1'b0);
    #2;
    chk("stall_minst", bus.minst, v.exp_minst);
    chk("stall_ready", bus.req_ready, 1'b0);
    step(1'b0, 1'b1, ~v.addr, 1'b1);
    step(1'b0, 1'b0, v.addr, 1'b0);
    #2;
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_minst", bus.minst, v.exp_minst);
  endtask
  initial begin
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.minstr_in = 1'b0; bus.minst_ready = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_addr = '0; bus0.minstr_in = 1'b0; bus0.minst_ready = 1'b0;
    tab[0] = '{10'h2A5, 44'hABCDE12345, 20, 10'b1010100101, 44'hABCDE12345};
    tab[1] = '{10'h000, 44'hFFFFFFFFFFF, 0, 10'h000, 44'hFFFFFFFFFFF};
    tab[2] = '{10'h3FF, 44'h00000000001, 3, 10'h3FF, 44'h00000000001};
    tab[3] = '{10'h001, 44'h80000000000, 1, 10'h001, 44'h80000000000};
    @(posedge clk);
    repeat (3) step(1'b1, 1'b1, 10'h3FF, 1'b1);
    step(1'b0, 1'b0, 10'h000, 1'b0);
    for (int k = 0; k < 4; k++) fetch(tab[k]);
    m_next = 44'h123456789AB;
    n_acc = 0;
    step(1'b0, 1'b1, 10'h000, 1'b1);
    m_next = 44'hFEDCBA98765;
    for (int i = 0; i < 200 && n_acc < 2; i++) step(1'b0, 1'b1, 10'h3FF, 1'b1);
    ones = 0;
    for (int i = 0; i < 200 && m_act; i++) step(1'b0, 1'b0, 10'h000, 1'b1);
    #2;
    chk("b2b_gap", acc_gap, 58);
    chk("b2b_ones", ones, 10);
    chk("b2b_minst", bus.minst, 44'hFEDCBA98765);
    m_next = 44'h0F0F0F0F0F0;
    step(1'b0, 1'b1, 10'h155, 1'b0);
    repeat (30) step(1'b0, 1'b0, 10'h000, 1'b0);
    step(1'b1, 1'b0, 10'h000, 1'b0);
    #2;
    chk("rst_sel", bus.mem_sel, 1'b0);
    chk("rst_minst", bus.minst, 44'h0);
    chk("rst_valid", bus.minst_valid, 1'b0);
    step(1'b0, 1'b0, 10'h000, 1'b0);
    fetch(tab[0]);
    for (int i = 0; i < 3000; i++) begin
      if (!m_act) m_next = {12'($urandom), $urandom};
      step($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, 10'($urandom), $urandom_range(0, 1) == 1);
    end
    step(1'b1, 1'b0, 10'h000, 1'b0);
    step(1'b0, 1'b0, 10'h000, 1'b0);
    @(negedge clk);
    bus0.req_valid = 1'b1;
    bus0.req_addr = addr0;
    @(posedge clk);
    for (int t = 0; t <= F0 + 1; t++) begin
      @(negedge clk);
      bus0.req_valid = 1'b0;
      bus0.minstr_in = (t >= AW && t < F0) ? w0[MW-1-(t-AW)] : 1'b1;
      #1;
      chk("ta0_valid", bus0.minst_valid, t >= F0);
      chk("ta0_sel", bus0.mem_sel, t < F0);
      if (t < AW) chk("ta0_stream", bus0.m_inst_addr_stream, addr0[AW-1-t]);
      @(posedge clk);
    end
    #2;
    chk("ta0_minst", bus0.minst, 44'h5A5C3C39669);
    @(negedge clk);
    bus0.minst_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("ta0_idle", bus0.busy, 1'b0);
    bus0.minst_ready = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
